// File: rtl/regfile_rdport_arbiter.sv
// Round-robin arbiter that shares one register-file read port among NREQ requesters.
// Grants drive a registered mux select; the result returns one cycle later with x0 and write forwarding applied.
module regfile_rdport_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Hold,
    input  logic [NREQ-1:0]      Req_valid,
    input  logic [NREQ*AW-1:0]   Req_addr,
    output logic [NREQ-1:0]      Req_ready,
    output logic [AW-1:0]        Sel,
    input  logic [DW-1:0]        Mux_Y,
    input  logic                 Wr_en,
    input  logic [AW-1:0]        Wr_addr,
    input  logic [DW-1:0]        Wr_data,
    output logic                 Rsp_valid,
    output logic [2:0]           Rsp_id,
    output logic [DW-1:0]        Rsp_data
);

    logic [AW-1:0]   sel_q, sel_d;
    logic [2:0]      last_q, last_d;
    logic [2:0]      s1_id_q, s1_id_d;
    logic            s1_v_q, s1_v_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [2:0]      rsp_id_q, rsp_id_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic            grant_found;
    logic [2:0]      grant_idx;
    logic [AW-1:0]   grant_addr;
    int unsigned     idx;

    // Scan positions last+1 .. last+NREQ (mod NREQ); first eligible requester wins.
    always_comb begin
        eligible    = Hold ? '0 : Req_valid;
        grant       = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_addr  = '0;
        idx         = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!grant_found && (i == idx) && eligible[i]) begin
                    grant_found = 1'b1;
                    grant[i]    = 1'b1;
                    grant_idx   = 3'(i);
                    grant_addr  = Req_addr[i*AW +: AW];
                end
            end
        end
    end

    assign Req_ready = Rst_n ? grant : '0;

    always_comb begin
        sel_d       = sel_q;
        last_d      = last_q;
        s1_id_d     = s1_id_q;
        s1_v_d      = grant_found;
        rsp_valid_d = s1_v_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (grant_found) begin
            sel_d   = grant_addr;
            s1_id_d = grant_idx;
            last_d  = grant_idx;
        end
        // x0 zero takes precedence over a same-cycle write to address 0.
        if (s1_v_q) begin
            rsp_id_d = s1_id_q;
            if (sel_q == '0)
                rsp_data_d = '0;
            else if (Wr_en && (Wr_addr == sel_q))
                rsp_data_d = Wr_data;
            else
                rsp_data_d = Mux_Y;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sel_q       <= '0;
            last_q      <= 3'(NREQ - 1);
            s1_id_q     <= '0;
            s1_v_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            sel_q       <= sel_d;
            last_q      <= last_d;
            s1_id_q     <= s1_id_d;
            s1_v_q      <= s1_v_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign Sel       = sel_q;
    assign Rsp_valid = rsp_valid_q;
    assign Rsp_id    = rsp_id_q;
    assign Rsp_data  = rsp_data_q;

endmodule

// File: doc/regfile_rdport_arbiter.md
Name: regfile_rdport_arbiter

Overview:
- Shares the single 32-entry register-file read port (one 32:1 read mux, 5-bit select, 32-bit result) among NREQ requesters, e.g. decode rs1, decode rs2, debug and CSR.
- Round-robin grant each cycle drives a registered select to the mux, samples the mux result one cycle later and returns it with the requester ID.
- Handles the x0 hard-zero case and write-port read-during-write forwarding.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 5, register address width
DW, 32, data width

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Hold  in  1  pipeline stall; blocks new grants
Req_valid  in  NREQ  per-requester read request
Req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
Req_ready  out  NREQ  one-hot grant, combinational
Sel  out  AW  registered select to read mux
Mux_Y  in  DW  read-mux output, combinational from Sel
Wr_en  in  1  register-file write enable, this cycle
Wr_addr  in  AW  register-file write address
Wr_data  in  DW  register-file write data
Rsp_valid  out  1  response strobe, one cycle
Rsp_id  out  3  index of the requester being answered
Rsp_data  out  DW  read data

Behaviour:
- Reset (Rst_n low, asynchronous) sets:
  - Sel=0, Rsp_valid=0, Rsp_id=0, Rsp_data=0.
  - Internal stage-1 valid s1_v=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority after reset.
- Req_ready is forced 0 while Rst_n=0.
- Arbitration, combinational:
  - Eligible = Req_valid, masked to all-zero when Hold=1.
  - Grant goes to the first eligible index scanning last+1, last+2, ... with modulo NREQ wrap.
  - Req_ready = one-hot grant, or 0 if nothing is eligible.
  - At most one grant per cycle.
- Acceptance: a request is accepted at edge t when Req_valid[i] and Req_ready[i] are both high. On that edge:
  - Sel <= Req_addr[i]
  - s1_id <= i
  - s1_v <= 1
  - last <= i
- No acceptance at an edge: s1_v <= 0, Sel and last hold.
- Stage 2, at edge t+1 (only when s1_v=1):
  - Rsp_valid <= 1, Rsp_id <= s1_id.
  - Rsp_data <= 0 if Sel==0 (x0).
  - Otherwise Rsp_data <= Wr_data if Wr_en and Wr_addr==Sel (forwarding; the write lands in the same cycle as the read).
  - Otherwise Rsp_data <= Mux_Y.
- When s1_v=0 at edge t+1: Rsp_valid <= 0; Rsp_id and Rsp_data hold their last values.
- Latency and throughput:
  - Response is visible 2 edges after acceptance.
  - Fully pipelined: one accept and one response per cycle, back to back.
- No response backpressure: the requester must sample Rsp_* in the cycle Rsp_valid=1.
- Hold:
  - Blocks only new grants.
  - A request already accepted (s1_v=1) still completes during Hold.
- Fairness: with all NREQ requesting continuously, grants cycle 0,1,..,NREQ-1,0; no requester waits more than NREQ-1 cycles once Hold=0.
- Requester behaviour:
  - A requester may drop Req_valid without being granted; nothing is latched.
  - Req_addr must be stable only in the accept cycle.
- Forwarding with Wr_addr==0 never overrides the x0 zero.
- Reset mid-operation: any in-flight s1 or response is discarded with no spurious Rsp_valid after release. The first grant after release goes to the lowest-index valid requester.
- NREQ not a power of two: wrap from NREQ-1 to 0. Rsp_id upper bits are 0.

Test Plan:
- Single read: mux model returns 0xDEAD0000|Sel. Req_valid=0001, Req_addr[0]=7 → Req_ready=0001, Sel=7 after edge, Rsp_valid=1, Rsp_id=0, Rsp_data=0xDEAD0007 one edge later.
- Round robin: all four requesting continuously, addrs 1,2,3,4 → grants 0,1,2,3,0,1.. on consecutive cycles; Rsp_id sequence 0,1,2,3,0 with Rsp_valid stuck at 1.
- x0 and forwarding:
  - Requester 1 reads addr 0 with Wr_en=1, Wr_addr=0, Wr_data=0x1234 → Rsp_data=0.
  - Requester 1 reads addr 9, with Wr_en=1, Wr_addr=9, Wr_data=0xCAFEBABE during the stage-2 cycle → Rsp_data=0xCAFEBABE, not Mux_Y.
- Hold: accept requester 2 at addr 5, then assert Hold for 3 cycles with all valid → the addr-5 response still emitted; Req_ready=0 and no Rsp_valid for the remaining Hold cycles; after release the grant resumes at requester 3.
- Reset mid-operation: accept a request, drop Rst_n asynchronously between edges before its response → Sel=0 and Rsp_valid=0 immediately with no response after release; with Req_valid=0110 the first grant is requester 1.
- Starvation bound: requester 0 valid continuously, requester 3 raises valid → requester 3 granted within 3 cycles.
